// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
//    Data-memory bus between the load/store unit and the data memory.
//    The request channel uses a valid/ready handshake. The response channel
//    carries read data with a valid strobe only; it has no back-pressure.
//
// Signals
//    mem_req_valid   LSU -> mem   request valid
//    mem_req_ready   mem -> LSU   memory accepts the request
//    mem_req_addr    LSU -> mem   word-aligned address
//    mem_req_we      LSU -> mem   1 = store
//    mem_req_wdata   LSU -> mem   lane-replicated store data
//    mem_req_wstrb   LSU -> mem   byte enables (0 for loads)
//    mem_resp_valid  mem -> LSU   read data valid
//    mem_resp_rdata  mem -> LSU   read word
//
// Modports
//    master  LSU side
//    slave   memory side
// ----------------------------------------------------------------------------
interface load_store_unit_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//    Memory-access stage. It accepts one load or store from execute, checks
//    funct3 and alignment, and runs one data-memory transaction. For loads it
//    extracts the addressed byte or halfword and sign- or zero-extends it. The
//    unit holds the pipeline with lsu_busy_o while an op is in flight.
//
// Ports
//    clk              clock, rising edge
//    rst_n            asynchronous active-low reset
//    ex_valid_i       execute presents an op
//    ex_opcode_i      opcode (0000011 load, 0100011 store; others ignored)
//    ex_funct3_i      access size / signedness
//    ex_addr_i        effective address
//    ex_store_data_i  store data (rs2)
//    lsu_busy_o       unit not idle; upstream holds ex_* and stalls
//    mem              data-memory bus (master side)
//    done_o           1-cycle pulse: op completed
//    wb_data_o        load result, valid with done_o (0 for stores)
//    err_o            1-cycle pulse: op aborted
//    err_cause_o      01 misaligned, 10 timeout, 11 illegal funct3
// ----------------------------------------------------------------------------
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ex_valid_i,
   input  logic [6:0]                ex_opcode_i,
   input  logic [2:0]                ex_funct3_i,
   input  logic [31:0]               ex_addr_i,
   input  logic [31:0]               ex_store_data_i,
   output logic                      lsu_busy_o,
   load_store_unit_if.master         mem,
   output logic                      done_o,
   output logic [31:0]               wb_data_o,
   output logic                      err_o,
   output logic [1:0]                err_cause_o
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        cause_q, cause_d;
   logic [31:0]       wb_q, wb_d;

   logic              isLoad, isStore, accept, illegalF3, misaligned;
   logic [31:0]       laneData;
   logic [3:0]        laneStrb;
   logic [7:0]        respByte;
   logic [15:0]       respHalf;
   logic [31:0]       loadValue;

   // Classify the op presented by execute. funct3 legality takes priority
   // over alignment, so misalignment is only meaningful for legal sizes.
   always_comb begin
      isLoad     = (ex_opcode_i == OP_LOAD);
      isStore    = (ex_opcode_i == OP_STORE);
      accept     = (state_q == IDLE) && ex_valid_i && (isLoad || isStore);
      illegalF3  = 1'b0;
      if (isLoad) begin
         illegalF3 = !(ex_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end else if (isStore) begin
         illegalF3 = !(ex_funct3_i inside {3'b000, 3'b001, 3'b010});
      end
      misaligned = ((ex_funct3_i[1:0] == 2'b01) && ex_addr_i[0]) ||
                   ((ex_funct3_i[1:0] == 2'b10) && (ex_addr_i[1:0] != 2'b00));
   end

   // Store data is replicated across all lanes so memory can pick whichever
   // bytes the strobe enables; loads never drive strobes.
   always_comb begin
      laneData = ex_store_data_i;
      laneStrb = 4'b0000;
      if (isStore) begin
         case (ex_funct3_i[1:0])
            2'b00: begin
               laneData = {4{ex_store_data_i[7:0]}};
               laneStrb = 4'b0001 << ex_addr_i[1:0];
            end
            2'b01: begin
               laneData = {2{ex_store_data_i[15:0]}};
               laneStrb = ex_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               laneData = ex_store_data_i;
               laneStrb = 4'b1111;
            end
         endcase
      end
   end

   // Pull the addressed byte/halfword out of the returned word and extend it
   // according to the latched funct3.
   always_comb begin
      respByte  = 8'(mem.mem_resp_rdata >> {addr_q[1:0], 3'b000});
      respHalf  = 16'(mem.mem_resp_rdata >> {addr_q[1], 4'b0000});
      case (funct3_q)
         3'b000:  loadValue = {{24{respByte[7]}}, respByte};
         3'b001:  loadValue = {{16{respHalf[15]}}, respHalf};
         3'b010:  loadValue = mem.mem_resp_rdata;
         3'b100:  loadValue = {24'd0, respByte};
         3'b101:  loadValue = {16'd0, respHalf};
         default: loadValue = 32'd0;
      endcase
   end

   // Next-state and pulse logic. Pulses default low every cycle so done and
   // err last exactly one cycle. A response that coincides with the final
   // timeout cycle still completes the load.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      cause_d  = 2'b00;
      wb_d     = 32'd0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (illegalF3) begin
                  err_d   = 1'b1;
                  cause_d = 2'b11;
               end else if (misaligned) begin
                  err_d   = 1'b1;
                  cause_d = 2'b01;
               end else begin
                  addr_d   = ex_addr_i;
                  funct3_d = ex_funct3_i;
                  we_d     = isStore;
                  wdata_d  = laneData;
                  wstrb_d  = laneStrb;
                  state_d  = REQ;
               end
            end
         end
         REQ: begin
            if (mem.mem_req_ready) begin
               if (we_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = WAIT_RESP;
               end
            end
         end
         WAIT_RESP: begin
            if (mem.mem_resp_valid) begin
               done_d  = 1'b1;
               wb_d    = loadValue;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               cause_d = 2'b10;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. An asynchronous reset abandons any op in
   // flight and clears every output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= 32'd0;
         funct3_q <= 3'd0;
         we_q     <= 1'b0;
         wdata_q  <= 32'd0;
         wstrb_q  <= 4'd0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cause_q  <= 2'b00;
         wb_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cause_q  <= cause_d;
         wb_q     <= wb_d;
      end
   end

   // Request fields come straight from registers latched at accept, so they
   // are stable for the whole time the request waits for ready.
   always_comb begin
      lsu_busy_o        = (state_q != IDLE);
      mem.mem_req_valid = (state_q == REQ);
      mem.mem_req_addr  = {addr_q[31:2], 2'b00};
      mem.mem_req_we    = we_q;
      mem.mem_req_wdata = wdata_q;
      mem.mem_req_wstrb = wstrb_q;
      done_o            = done_q;
      wb_data_o         = wb_q;
      err_o             = err_q;
      err_cause_o       = cause_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//    Directed self-checking bench for load_store_unit. Each task drives one
//    scenario and compares outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int T = 16;
   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr;
   logic [31:0] ex_store_data;
   logic        lsu_busy;
   logic        done;
   logic [31:0] wb_data;
   logic        err;
   logic [1:0]  err_cause;

   int total;
   int bad;

   load_store_unit_if memIf ();

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ex_valid_i      (ex_valid),
      .ex_opcode_i     (ex_opcode),
      .ex_funct3_i     (ex_funct3),
      .ex_addr_i       (ex_addr),
      .ex_store_data_i (ex_store_data),
      .lsu_busy_o      (lsu_busy),
      .mem             (memIf.master),
      .done_o          (done),
      .wb_data_o       (wb_data),
      .err_o           (err),
      .err_cause_o     (err_cause)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle and settle just past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for exactly one accepting edge, then withdraw it.
   task automatic issueOp(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data);
      ex_opcode     = op;
      ex_funct3     = f3;
      ex_addr       = addr;
      ex_store_data = data;
      ex_valid      = 1'b1;
      tick();
      ex_valid      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_opcode = 7'd0; ex_funct3 = 3'd0; ex_addr = 32'd0; ex_store_data = 32'd0;
      memIf.mem_req_ready = 1'b0; memIf.mem_resp_valid = 1'b0; memIf.mem_resp_rdata = 32'd0;
      tick(); tick();
      total++; if (lsu_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", lsu_busy); end
      total++; if (memIf.mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid got=%b want=0", memIf.mem_req_valid); end
      total++; if ({memIf.mem_req_addr, memIf.mem_req_wdata, memIf.mem_req_wstrb, memIf.mem_req_we} !== 69'd0) begin
         bad++; $display("[TB] FAIL reset_req_fields got=%h/%h/%h/%b want=0", memIf.mem_req_addr, memIf.mem_req_wdata, memIf.mem_req_wstrb, memIf.mem_req_we); end
      total++; if ({done, err, err_cause, wb_data} !== 36'd0) begin
         bad++; $display("[TB] FAIL reset_pulses got done=%b err=%b cause=%b wb=%h want=0", done, err, err_cause, wb_data); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_lw();
      memIf.mem_req_ready = 1'b1;
      issueOp(LOAD, 3'b010, 32'h100, 32'd0);
      total++; if (memIf.mem_req_valid !== 1'b1 || memIf.mem_req_addr !== 32'h100 || memIf.mem_req_we !== 1'b0 || memIf.mem_req_wstrb !== 4'b0000) begin
         bad++; $display("[TB] FAIL lw_req got valid=%b addr=%h we=%b strb=%b want 1/00000100/0/0000", memIf.mem_req_valid, memIf.mem_req_addr, memIf.mem_req_we, memIf.mem_req_wstrb); end
      total++; if (lsu_busy !== 1'b1) begin bad++; $display("[TB] FAIL lw_busy got=%b want=1", lsu_busy); end
      tick();
      total++; if (memIf.mem_req_valid !== 1'b0 || done !== 1'b0) begin
         bad++; $display("[TB] FAIL lw_wait got valid=%b done=%b want 0/0", memIf.mem_req_valid, done); end
      memIf.mem_resp_valid = 1'b1; memIf.mem_resp_rdata = 32'hDEADBEEF;
      tick();
      memIf.mem_resp_valid = 1'b0;
      total++; if (done !== 1'b1 || wb_data !== 32'hDEADBEEF || err !== 1'b0 || lsu_busy !== 1'b0) begin
         bad++; $display("[TB] FAIL lw_done got done=%b wb=%h err=%b busy=%b want 1/deadbeef/0/0", done, wb_data, err, lsu_busy); end
      tick();
      total++; if (done !== 1'b0 || wb_data !== 32'd0) begin bad++; $display("[TB] FAIL lw_pulse got done=%b wb=%h want 0/0", done, wb_data); end
   endtask

   task automatic test_load_extend();
      logic [2:0]  f3s  [6];
      logic [31:0] adrs [6];
      logic [31:0] exps [6];
      f3s[0] = 3'b000; adrs[0] = 32'h203; exps[0] = 32'hFFFFFF80;
      f3s[1] = 3'b100; adrs[1] = 32'h203; exps[1] = 32'h00000080;
      f3s[2] = 3'b001; adrs[2] = 32'h202; exps[2] = 32'hFFFF80FF;
      f3s[3] = 3'b101; adrs[3] = 32'h202; exps[3] = 32'h000080FF;
      f3s[4] = 3'b000; adrs[4] = 32'h202; exps[4] = 32'hFFFFFFFF;
      f3s[5] = 3'b001; adrs[5] = 32'h200; exps[5] = 32'h00000000;
      memIf.mem_req_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issueOp(LOAD, f3s[i], adrs[i], 32'd0);
         total++; if (memIf.mem_req_addr !== 32'h200) begin bad++; $display("[TB] FAIL ext%0d_addr got=%h want=00000200", i, memIf.mem_req_addr); end
         tick();
         memIf.mem_resp_valid = 1'b1; memIf.mem_resp_rdata = 32'h80FF0000;
         tick();
         memIf.mem_resp_valid = 1'b0;
         total++; if (done !== 1'b1 || wb_data !== exps[i]) begin
            bad++; $display("[TB] FAIL ext%0d_wb got done=%b wb=%h want 1/%h", i, done, wb_data, exps[i]); end
      end
      tick();
   endtask

   task automatic test_store_stall();
      memIf.mem_req_ready = 1'b0;
      issueOp(STORE, 3'b001, 32'h302, 32'h1234ABCD);
      for (int i = 0; i < 3; i++) begin
         total++; if (memIf.mem_req_valid !== 1'b1 || memIf.mem_req_addr !== 32'h300 || memIf.mem_req_we !== 1'b1 ||
                      memIf.mem_req_wdata !== 32'hABCDABCD || memIf.mem_req_wstrb !== 4'b1100 || done !== 1'b0) begin
            bad++; $display("[TB] FAIL sh_stall%0d got v=%b a=%h we=%b d=%h s=%b done=%b want 1/300/1/abcdabcd/1100/0",
                            i, memIf.mem_req_valid, memIf.mem_req_addr, memIf.mem_req_we, memIf.mem_req_wdata, memIf.mem_req_wstrb, done); end
         tick();
      end
      memIf.mem_req_ready = 1'b1;
      tick();
      total++; if (done !== 1'b1 || wb_data !== 32'd0 || lsu_busy !== 1'b0 || memIf.mem_req_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL sh_done got done=%b wb=%h busy=%b v=%b want 1/0/0/0", done, wb_data, lsu_busy, memIf.mem_req_valid); end
      tick();
   endtask

   task automatic test_store_lanes();
      logic [2:0]  f3s  [4];
      logic [31:0] adrs [4];
      logic [31:0] dats [4];
      logic [31:0] wds  [4];
      logic [3:0]  sts  [4];
      f3s[0] = 3'b000; adrs[0] = 32'h11; dats[0] = 32'h000000A5; wds[0] = 32'hA5A5A5A5; sts[0] = 4'b0010;
      f3s[1] = 3'b000; adrs[1] = 32'h13; dats[1] = 32'hFFFFFF3C; wds[1] = 32'h3C3C3C3C; sts[1] = 4'b1000;
      f3s[2] = 3'b001; adrs[2] = 32'h10; dats[2] = 32'h99995678; wds[2] = 32'h56785678; sts[2] = 4'b0011;
      f3s[3] = 3'b010; adrs[3] = 32'h20; dats[3] = 32'hCAFEF00D; wds[3] = 32'hCAFEF00D; sts[3] = 4'b1111;
      memIf.mem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issueOp(STORE, f3s[i], adrs[i], dats[i]);
         total++; if (memIf.mem_req_wdata !== wds[i] || memIf.mem_req_wstrb !== sts[i] || memIf.mem_req_addr !== {adrs[i][31:2], 2'b00}) begin
            bad++; $display("[TB] FAIL st%0d_lane got d=%h s=%b a=%h want %h/%b", i, memIf.mem_req_wdata, memIf.mem_req_wstrb, memIf.mem_req_addr, wds[i], sts[i]); end
         tick();
         total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL st%0d_done got=%b want=1", i, done); end
      end
      tick();
   endtask

   task automatic test_errors();
      logic [6:0]  ops  [6];
      logic [2:0]  f3s  [6];
      logic [31:0] adrs [6];
      logic [1:0]  cas  [6];
      ops[0] = LOAD;  f3s[0] = 3'b010; adrs[0] = 32'h101; cas[0] = 2'b01;
      ops[1] = LOAD;  f3s[1] = 3'b011; adrs[1] = 32'h100; cas[1] = 2'b11;
      ops[2] = STORE; f3s[2] = 3'b011; adrs[2] = 32'h101; cas[2] = 2'b11;
      ops[3] = LOAD;  f3s[3] = 3'b001; adrs[3] = 32'h201; cas[3] = 2'b01;
      ops[4] = STORE; f3s[4] = 3'b001; adrs[4] = 32'h203; cas[4] = 2'b01;
      ops[5] = STORE; f3s[5] = 3'b100; adrs[5] = 32'h200; cas[5] = 2'b11;
      memIf.mem_req_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issueOp(ops[i], f3s[i], adrs[i], 32'h55);
         total++; if (err !== 1'b1 || err_cause !== cas[i] || done !== 1'b0 || memIf.mem_req_valid !== 1'b0 || lsu_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL err%0d got err=%b cause=%b done=%b v=%b busy=%b want 1/%b/0/0/0",
                            i, err, err_cause, done, memIf.mem_req_valid, lsu_busy, cas[i]); end
         tick();
         total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL err%0d_pulse got=%b want=0", i, err); end
      end
      issueOp(7'b0110011, 3'b010, 32'h100, 32'd0);
      total++; if (lsu_busy !== 1'b0 || memIf.mem_req_valid !== 1'b0 || err !== 1'b0) begin
         bad++; $display("[TB] FAIL ignore_op got busy=%b v=%b err=%b want 0/0/0", lsu_busy, memIf.mem_req_valid, err); end
   endtask

   task automatic test_timeout();
      int n;
      memIf.mem_req_ready = 1'b1;
      issueOp(LOAD, 3'b010, 32'h400, 32'd0);
      tick();
      n = 0;
      while (err !== 1'b1 && done !== 1'b1 && n < T + 10) begin
         tick();
         n++;
      end
      total++; if (err !== 1'b1 || err_cause !== 2'b10 || done !== 1'b0 || n != T) begin
         bad++; $display("[TB] FAIL timeout got err=%b cause=%b done=%b cycles=%0d want 1/10/0/%0d", err, err_cause, done, n, T); end
      memIf.mem_resp_valid = 1'b1; memIf.mem_resp_rdata = 32'h12345678;
      tick(); tick();
      memIf.mem_resp_valid = 1'b0;
      total++; if (done !== 1'b0 || lsu_busy !== 1'b0 || err !== 1'b0) begin
         bad++; $display("[TB] FAIL late_resp got done=%b busy=%b err=%b want 0/0/0", done, lsu_busy, err); end
      // Response on the last allowed wait cycle must win over the timeout.
      issueOp(LOAD, 3'b010, 32'h400, 32'd0);
      tick();
      for (int i = 0; i < T - 1; i++) tick();
      memIf.mem_resp_valid = 1'b1; memIf.mem_resp_rdata = 32'h0BADF00D;
      tick();
      memIf.mem_resp_valid = 1'b0;
      total++; if (done !== 1'b1 || err !== 1'b0 || wb_data !== 32'h0BADF00D) begin
         bad++; $display("[TB] FAIL resp_vs_timeout got done=%b err=%b wb=%h want 1/0/0badf00d", done, err, wb_data); end
      tick();
   endtask

   task automatic test_reset_mid();
      memIf.mem_req_ready = 1'b1;
      issueOp(LOAD, 3'b010, 32'h500, 32'd0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      total++; if (lsu_busy !== 1'b0 || memIf.mem_req_valid !== 1'b0 || memIf.mem_req_addr !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin
         bad++; $display("[TB] FAIL rst_mid got busy=%b v=%b a=%h done=%b err=%b want 0", lsu_busy, memIf.mem_req_valid, memIf.mem_req_addr, done, err); end
      memIf.mem_resp_valid = 1'b1; memIf.mem_resp_rdata = 32'hFFFFFFFF;
      tick();
      rst_n = 1'b1;
      tick();
      memIf.mem_resp_valid = 1'b0;
      total++; if (done !== 1'b0 || lsu_busy !== 1'b0) begin
         bad++; $display("[TB] FAIL rst_stale_resp got done=%b busy=%b want 0/0", done, lsu_busy); end
      issueOp(LOAD, 3'b010, 32'h104, 32'd0);
      tick();
      memIf.mem_resp_valid = 1'b1; memIf.mem_resp_rdata = 32'hA5A55A5A;
      tick();
      memIf.mem_resp_valid = 1'b0;
      total++; if (done !== 1'b1 || wb_data !== 32'hA5A55A5A) begin
         bad++; $display("[TB] FAIL rst_recover got done=%b wb=%h want 1/a5a55a5a", done, wb_data); end
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_lw();
      test_load_extend();
      test_store_stall();
      test_store_lanes();
      test_errors();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
